// File: rtl/dcpu_intctrl.sv
// Memory-mapped interrupt controller feeding the dcpu core's level interrupt input.
// Define DCPU_INTCTRL_SYNC_EN to insert a 2-flop synchroniser on every source.
module dcpu_intctrl #(
  parameter int unsigned NSRC      = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NSRC-1:0] i_src,
  input  logic [15:0]     i_addr,
  input  logic [15:0]     i_dat,
  input  logic            i_rw,
  output logic [15:0]     o_dat,
  output logic            o_sel,
  output logic            o_int
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_VECTOR = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_prev;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_d;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] w1c;
  logic            gie;
  logic            wr_en;
  logic [2:0]      word;
  logic [IW-1:0]   vec_idx;
  logic [DW-1:0]   vector;
  logic            unused_bits;

  assign o_sel       = (i_addr[15:4] == BASE_ADDR[15:4]);
  assign wr_en       = o_sel & ~i_rw;
  assign word        = i_addr[3:1];
  assign unused_bits = ^{i_addr[0], i_dat};

`ifdef DCPU_INTCTRL_SYNC_EN
  logic [NSRC-1:0] sync_q1;
  logic [NSRC-1:0] sync_q2;

  // Two-stage synchroniser for sources asynchronous to i_clk
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= i_src;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = i_src;
`endif

  // Edge mode: set beats a same-cycle clear; level mode tracks the source
  always_comb begin
    w1c = '0;
    if (wr_en && (word == OFF_PEND)) begin
      w1c = i_dat[NSRC-1:0];
    end
    pend_d = (edge_mode & ((pend & ~w1c) | (s & ~s_prev))) | (~edge_mode & s);
  end

  // Lowest-numbered enabled pending source wins
  always_comb begin
    active  = pend & enable;
    vec_idx = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx = IW'(i);
      end
    end
    vector = {|active, 11'b0, vec_idx};
  end

  // Zero-latency read mux; the core samples read data in the address cycle
  always_comb begin
    o_dat = '0;
    if (o_sel) begin
      case (word)
        OFF_PEND:   o_dat = DW'(pend);
        OFF_ENABLE: o_dat = DW'(enable);
        OFF_EDGE:   o_dat = DW'(edge_mode);
        OFF_VECTOR: o_dat = vector;
        OFF_CTRL:   o_dat = DW'(gie);
        default:    o_dat = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend      <= '0;
      enable    <= '0;
      edge_mode <= '0;
      gie       <= 1'b0;
      s_prev    <= '0;
      o_int     <= 1'b0;
    end else begin
      pend   <= pend_d;
      s_prev <= s;
      o_int  <= gie & (|(pend & enable));
      if (wr_en) begin
        case (word)
          OFF_ENABLE: enable    <= i_dat[NSRC-1:0];
          OFF_EDGE:   edge_mode <= i_dat[NSRC-1:0];
          OFF_CTRL:   gie       <= i_dat[0];
          default:    ;
        endcase
      end
    end
  end

endmodule
